requant_relu_serializer: RTL
============================

// Module: requant_relu_serializer
// PURPOSE
//   Consumes the 8-channel x 4-pixel accumulated partial sums from the channel
//   adder once accumulation completes. Adds per-channel bias, applies arithmetic
//   right shift with rounding, optional ReLU and saturation to activation width.
//   Emits one channel (4 pixels) per beat over a valid/ready port to the
//   activation SRAM writer, with backpressure.
// PARAMETERS
//   ACT_PER_ADDR  4   pixels per channel word
//   BW_PER_ACT    12  output activation bits (signed)
//   BW_PER_PARAM  8   bias bits (signed)
//   ADDER_BW      29  accumulator bits per pixel (signed)
//   CH_OUT        8   channels captured per accumulation
//   SHIFT_BW      5   width of quant_shift
// PORTS
//   clk          in   1                    clock, rising edge
//   srst_n       in   1                    reset, asynchronous, active-low
//   acc_valid    in   1                    add_ch* hold final sums this cycle
//   acc_ready    out  1                    block idle, can capture
//   add_ch0..7   in   ADDER_BW*4 each      accumulated sums, pixel0 in LSBs
//   bias         in   BW_PER_PARAM*8       bias per channel, ch0 in LSBs
//   quant_shift  in   SHIFT_BW             right-shift amount, 0..24
//   relu_en      in   1                    1: clamp negatives to 0
//   out_valid    out  1                    act_data valid
//   out_ready    in   1                    sink accepts beat
//   act_data     out  BW_PER_ACT*4         4 signed activations, pixel0 in LSBs
//   act_ch       out  3                    channel index of act_data
//   act_last     out  1                    beat is channel 7
//   err_overrun  out  1                    sticky: acc_valid while not ready
// BEHAVIOUR
//   - Reset (async): state IDLE, acc_ready=1, out_valid=0, act_data=0, act_ch=0,
//     act_last=0, err_overrun=0, pipeline valids=0.
//   - FSM IDLE->DRAIN on acc_valid&&acc_ready. Capture all add_ch*, bias,
//     quant_shift and relu_en into regs. Capture regs are stable during drain.
//   - DRAIN->IDLE on the edge where the ch7 beat completes (out_valid&&out_ready&&act_last).
//     acc_ready=1 only in IDLE, so capture is possible on the following cycle.
//   - acc_valid while acc_ready=0: ignored, err_overrun<=1 until reset.
//   - Pipeline, 2 stages, advance when !out_valid||out_ready:
//     S1: sum = sext(acc,ADDER_BW+1) + sext(bias[ch]); register.
//     S2: r = (sum + (sh?1<<(sh-1):0)) >>> sh. Round half toward +inf.
//     Width ADDER_BW+1 with no overflow. Then relu (r<0 -> 0 if relu_en).
//     Then saturate to [-2^(BW_PER_ACT-1), 2^(BW_PER_ACT-1)-1]. Register to act_data.
//   - Latency: capture at edge E0; ch0 beat out_valid=1 after E2. With out_ready=1,
//     8 consecutive beats follow, ch0..ch7.
//   - Stall: while out_valid&&!out_ready, act_data/act_ch/act_last hold. S1 and
//     the channel counter also hold, so no beat is lost or duplicated.
//   - Channel counter 3-bit, issues ch0..7 into S1 once each, then stops.
//     No wrap into a 9th issue.
//   - quant_shift>24 is treated as 24.
//   - Reset mid-drain: all beats discarded, back to IDLE.
// STRUCTURE
//   - Shared package: ADDER_BW, BW_PER_ACT, BW_PER_PARAM defaults.
//     Also the FSM state encoding (IDLE=0, DRAIN=1) and the SAT_MAX/SAT_MIN constants.
//   - One sub-module requant_lane: combinational round/shift/relu/saturate for one
//     pixel, instantiated 4x in S2. The FSM, capture regs and handshake stay in top.
// TESTING
//   1. All acc=1000, bias=0, shift=2, relu=0, out_ready=1.
//      Expect 8 beats, ch0..7, every pixel 250, act_last on ch7 only, out_valid after E2.
//   2. acc=-7, bias=0, shift=1. Expect -3 (round half up).
//      With relu_en=1, expect 0. acc=5, shift=1 gives 3.
//   3. Saturation, shift=0: acc=3000 gives 2047. acc=-5000 gives -2048.
//      acc=2^28-1 with bias=127 gives 2047, with no wrap.
//   4. Bias per channel: ch k bias=k-4, acc=16, shift=0. Expect pixel values 12+k.
//   5. Backpressure: out_ready random 50%.
//      Expect act_data stable while stalled, exactly 8 beats in order, acc_ready=0 until ch7 accepted.
//   6. acc_valid pulse during drain: err_overrun=1, drained data unchanged.
//      Assert srst_n mid-drain: outputs reset at once, next capture drains normally.

Source files
------------

// File: rtl/requant_relu_serializer_pkg.sv
// rtl/requant_relu_serializer_pkg.sv - shared widths, FSM encoding and saturation limits
package requant_relu_serializer_pkg;

  localparam int ACT_PER_ADDR = 4;
  localparam int BW_PER_ACT   = 12;
  localparam int BW_PER_PARAM = 8;
  localparam int ADDER_BW     = 29;
  localparam int CH_OUT       = 8;
  localparam int SHIFT_BW     = 5;
  localparam int CH_BW        = 3;
  localparam int SHIFT_MAX    = 24;
  // One extra bit holds acc + bias + rounding constant without overflow.
  localparam int SUM_BW       = ADDER_BW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic signed [SUM_BW-1:0] SAT_MAX = SUM_BW'((1 << (BW_PER_ACT - 1)) - 1);
  localparam logic signed [SUM_BW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic [SHIFT_BW-1:0] clamp_shift(input logic [SHIFT_BW-1:0] sh);
    return (sh > SHIFT_BW'(SHIFT_MAX)) ? SHIFT_BW'(SHIFT_MAX) : sh;
  endfunction

endpackage

// File: rtl/requant_relu_serializer_lane.sv
// rtl/requant_relu_serializer_lane.sv - combinational round/shift/relu/saturate for one pixel
// Ports:
//   i_sum   biased sum (signed, SUM_BW)
//   i_shift right-shift amount, already clamped to 0..24
//   i_relu  1: negative results become 0
//   o_act   saturated signed activation
module requant_lane
  import requant_relu_serializer_pkg::*;
(
  input  logic [SUM_BW-1:0]     i_sum,
  input  logic [SHIFT_BW-1:0]   i_shift,
  input  logic                  i_relu,
  output logic [BW_PER_ACT-1:0] o_act
);

  logic        [SUM_BW-1:0] w_rnd;
  logic signed [SUM_BW-1:0] w_biased;
  logic signed [SUM_BW-1:0] w_shr;
  logic signed [SUM_BW-1:0] w_relu;

  always_comb begin
    // Adding half an LSB before the floor shift rounds ties toward +inf.
    w_rnd = '0;
    if (i_shift != '0) begin
      w_rnd = SUM_BW'(1) << (i_shift - 1'b1);
    end
    w_biased = $signed(i_sum) + $signed(w_rnd);
    w_shr    = w_biased >>> i_shift;
    w_relu   = (i_relu && w_shr[SUM_BW-1]) ? '0 : w_shr;
    if (w_relu > SAT_MAX) begin
      o_act = SAT_MAX[BW_PER_ACT-1:0];
    end else if (w_relu < SAT_MIN) begin
      o_act = SAT_MIN[BW_PER_ACT-1:0];
    end else begin
      o_act = w_relu[BW_PER_ACT-1:0];
    end
  end

endmodule

// File: rtl/requant_relu_serializer.sv
// rtl/requant_relu_serializer.sv - capture 8ch x 4px sums, requantize, stream one channel per beat
// Ports:
//   clk, srst_n              clock, async active-low reset
//   acc_valid / acc_ready    capture handshake for add_ch0..7, bias, quant_shift, relu_en
//   out_valid / out_ready    output beat handshake
//   act_data, act_ch, act_last  4 activations, channel index, last-channel flag
//   err_overrun              sticky: acc_valid seen while busy
module requant_relu_serializer
  import requant_relu_serializer_pkg::*;
(
  input  logic                               clk,
  input  logic                               srst_n,
  input  logic                               acc_valid,
  output logic                               acc_ready,
  input  logic [ADDER_BW*ACT_PER_ADDR-1:0]   add_ch0,
  input  logic [ADDER_BW*ACT_PER_ADDR-1:0]   add_ch1,
  input  logic [ADDER_BW*ACT_PER_ADDR-1:0]   add_ch2,
  input  logic [ADDER_BW*ACT_PER_ADDR-1:0]   add_ch3,
  input  logic [ADDER_BW*ACT_PER_ADDR-1:0]   add_ch4,
  input  logic [ADDER_BW*ACT_PER_ADDR-1:0]   add_ch5,
  input  logic [ADDER_BW*ACT_PER_ADDR-1:0]   add_ch6,
  input  logic [ADDER_BW*ACT_PER_ADDR-1:0]   add_ch7,
  input  logic [BW_PER_PARAM*CH_OUT-1:0]     bias,
  input  logic [SHIFT_BW-1:0]                quant_shift,
  input  logic                               relu_en,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [BW_PER_ACT*ACT_PER_ADDR-1:0] act_data,
  output logic [CH_BW-1:0]                   act_ch,
  output logic                               act_last,
  output logic                               err_overrun
);

  logic [ADDER_BW*ACT_PER_ADDR-1:0]   w_add [CH_OUT];
  state_e                             r_state;
  logic [ADDER_BW*ACT_PER_ADDR-1:0]   r_acc [CH_OUT];
  logic [BW_PER_PARAM*CH_OUT-1:0]     r_bias;
  logic [SHIFT_BW-1:0]                r_shift;
  logic                               r_relu;
  logic [CH_BW-1:0]                   r_cnt;
  logic                               r_issued_all;
  logic                               r_s1_valid;
  logic [CH_BW-1:0]                   r_s1_ch;
  logic [SUM_BW-1:0]                  r_s1_sum [ACT_PER_ADDR];
  logic                               w_adv;
  logic                               w_issue;
  logic                               w_capture;
  logic [ADDER_BW*ACT_PER_ADDR-1:0]   w_cur_acc;
  logic [BW_PER_PARAM-1:0]            w_cur_bias;
  logic [SUM_BW-1:0]                  w_bias_ext;
  logic [SUM_BW-1:0]                  w_s1_next [ACT_PER_ADDR];
  logic [BW_PER_ACT*ACT_PER_ADDR-1:0] w_lane_act;

  assign w_add[0] = add_ch0;
  assign w_add[1] = add_ch1;
  assign w_add[2] = add_ch2;
  assign w_add[3] = add_ch3;
  assign w_add[4] = add_ch4;
  assign w_add[5] = add_ch5;
  assign w_add[6] = add_ch6;
  assign w_add[7] = add_ch7;

  assign acc_ready = (r_state == ST_IDLE);
  assign w_capture = acc_valid && acc_ready;
  // The whole pipeline moves only when the output register is free or being drained.
  assign w_adv     = !out_valid || out_ready;
  assign w_issue   = (r_state == ST_DRAIN) && !r_issued_all;

  assign w_cur_acc  = r_acc[r_cnt];
  assign w_cur_bias = r_bias[int'(r_cnt)*BW_PER_PARAM +: BW_PER_PARAM];
  assign w_bias_ext = {{(SUM_BW-BW_PER_PARAM){w_cur_bias[BW_PER_PARAM-1]}}, w_cur_bias};

  always_comb begin
    for (int p = 0; p < ACT_PER_ADDR; p++) begin
      w_s1_next[p] = {w_cur_acc[p*ADDER_BW+ADDER_BW-1], w_cur_acc[p*ADDER_BW +: ADDER_BW]}
                     + w_bias_ext;
    end
  end

  genvar g;
  generate
    for (g = 0; g < ACT_PER_ADDR; g++) begin : g_lane
      requant_lane u_lane (
        .i_sum   (r_s1_sum[g]),
        .i_shift (r_shift),
        .i_relu  (r_relu),
        .o_act   (w_lane_act[g*BW_PER_ACT +: BW_PER_ACT])
      );
    end
  endgenerate

  // Data-only registers: qualified by the control valids, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < CH_OUT; k++) begin
        r_acc[k] <= w_add[k];
      end
      r_bias  <= bias;
      r_shift <= clamp_shift(quant_shift);
      r_relu  <= relu_en;
    end
    if (w_adv && w_issue) begin
      for (int p = 0; p < ACT_PER_ADDR; p++) begin
        r_s1_sum[p] <= w_s1_next[p];
      end
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_issued_all <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_ch      <= '0;
      out_valid    <= 1'b0;
      act_data     <= '0;
      act_ch       <= '0;
      act_last     <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if (acc_valid && !acc_ready) begin
        err_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (acc_valid) begin
            r_state      <= ST_DRAIN;
            r_cnt        <= '0;
            r_issued_all <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready && act_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_adv) begin
        out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          act_data <= w_lane_act;
          act_ch   <= r_s1_ch;
          act_last <= (r_s1_ch == CH_BW'(CH_OUT - 1));
        end
        r_s1_valid <= w_issue;
        if (w_issue) begin
          r_s1_ch <= r_cnt;
          r_cnt   <= r_cnt + 1'b1;
          // Counter stops after the last channel; no ninth issue.
          if (r_cnt == CH_BW'(CH_OUT - 1)) begin
            r_issued_all <= 1'b1;
          end
        end
      end
    end
  end

endmodule
